serial_addsub: RTL

- Parametrised bit-serial adder/subtractor, the multi-bit sequential successor to the single-bit combinational adder.
- Latches two WIDTH-bit operands on a start pulse and processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Returns a registered sum, carry/no-borrow, signed overflow and a one-cycle done pulse.
- Used where adder area matters more than latency.

---
 rtl/serial_addsub_if.sv | 25 ++
 rtl/serial_addsub.sv | 110 +++++++++++
 2 files changed

// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master pulses start with sub/a/b valid in an edge where busy is 0; the slave answers with done for one cycle.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carry, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carry, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// WIDTH cycles per operation with registered sum/carry/overflow and a done pulse.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_addsub_if.slave     bus,
  output logic [1:0]         dbg_state_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_bit;
  logic             c_out;
  logic             last_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    sum_d     = sum_q;
    c_d       = c_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    s_bit     = opa_q[0] ^ opb_q[0] ^ c_q;
    c_out     = (opa_q[0] & opb_q[0]) | (opa_q[0] & c_q) | (opb_q[0] & c_q);
    last_bit  = (cnt_q == CW'(WIDTH - 1));
    res_shift = res_q >> 1;
    res_shift[WIDTH-1] = s_bit;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1: the +1 enters through the carry flop.
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        c_d   = c_out;
        res_d = res_shift;
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          // c_q here is the carry into the MSB stage.
          sum_d   = res_shift;
          carry_d = c_out;
          ovf_d   = c_q ^ c_out;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.sum      = sum_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign dbg_state_o  = state_q;
endmodule
